// File: rtl/rv_rr_arb.sv
// rv_rr_arb: packet-aware round-robin arbiter feeding one registered valid-ready output
// Ports:
//   clk, rst_n                     clock (rising edge), asynchronous active-low reset
//   datain_val/datain_last [N]     per-requester valid and end-of-packet flag
//   datain [N*wd]                  requester i data at [i*wd +: wd]
//   datain_rdy [N]                 per-requester ready, one-hot or zero
//   dataout_val/dataout_rdy        registered output handshake
//   dataout/dataout_id/dataout_last registered beat, source index, end-of-packet
module rv_rr_arb #(
    parameter int wd  = 4,
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      datain_val,
    output logic [N-1:0]      datain_rdy,
    input  logic [N*wd-1:0]   datain,
    input  logic [N-1:0]      datain_last,
    output logic              dataout_val,
    input  logic              dataout_rdy,
    output logic [wd-1:0]     dataout,
    output logic [IDW-1:0]    dataout_id,
    output logic              dataout_last
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t         state, state_d;
    logic [IDW-1:0] owner, owner_d, rr_ptr, rr_ptr_d, g;
    logic           gv, ld, accept, sel_last;
    logic [wd-1:0]  sel_data;
    assign ld = !dataout_val || dataout_rdy;
    // Scan downward so the requester closest to rr_ptr is the last, and winning, assignment.
    always_comb begin
        gv = 1'b0;
        g  = '0;
        if (state == LOCKED) begin
            gv = 1'b1;
            g  = owner;
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (datain_val[(int'(rr_ptr) + k) % N]) begin
                    gv = 1'b1;
                    g  = IDW'((int'(rr_ptr) + k) % N);
                end
            end
        end
    end
    assign datain_rdy = (ld && gv) ? N'(1) << g : '0;
    assign accept     = |(datain_val & datain_rdy);
    assign sel_data   = datain[int'(g)*wd +: wd];
    assign sel_last   = datain_last[int'(g)];
    // While LOCKED, g equals owner, so one last-beat branch releases both states.
    always_comb begin
        state_d  = state;
        owner_d  = owner;
        rr_ptr_d = rr_ptr;
        if (accept) begin
            if (state == IDLE && !sel_last) begin
                state_d = LOCKED;
                owner_d = g;
            end else if (sel_last) begin
                state_d  = IDLE;
                rr_ptr_d = IDW'((int'(g) + 1) % N);
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= '0;
            rr_ptr       <= '0;
            dataout_val  <= 1'b0;
            dataout      <= '0;
            dataout_id   <= '0;
            dataout_last <= 1'b0;
        end else begin
            state  <= state_d;
            owner  <= owner_d;
            rr_ptr <= rr_ptr_d;
            if (ld) begin
                dataout_val <= accept;
                if (accept) begin
                    dataout      <= sel_data;
                    dataout_id   <= g;
                    dataout_last <= sel_last;
                end
            end
        end
    end
endmodule

// File: tb/tb_rv_rr_arb.sv
// tb_rv_rr_arb: scoreboard bench for rv_rr_arb with directed and random packet traffic
module tb_rv_rr_arb;
    localparam int N = 4, WD = 4, IDW = 2;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] val, last, datain_rdy, pause;
    logic [WD-1:0] dat [N];
    logic [N*WD-1:0] datain;
    logic dataout_rdy, dataout_val, dataout_last;
    logic [WD-1:0] dataout;
    logic [IDW-1:0] dataout_id;
    typedef struct packed {logic [IDW-1:0] id; logic l; logic [WD-1:0] d;} beat_t;
    beat_t exp_q[$];
    logic [WD:0] pk [N][64];
    int hd [N], tl [N];
    int compared = 0, mismatched = 0;
    bit m_ov;
    int m_owner, m_ptr;

    always #5 clk = ~clk;
    always_comb begin
        datain = '0;
        for (int i = 0; i < N; i++) datain[i*WD +: WD] = dat[i];
    end

    rv_rr_arb #(.wd(WD), .N(N), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .datain_val(val), .datain_rdy(datain_rdy),
        .datain(datain), .datain_last(last), .dataout_val(dataout_val),
        .dataout_rdy(dataout_rdy), .dataout(dataout), .dataout_id(dataout_id),
        .dataout_last(dataout_last));

    function automatic void check(string name, int act, int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    task automatic push(int i, int d, bit l);
        pk[i][tl[i] % 64] = {l, WD'(d)};
        tl[i]++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            val[i]  = (hd[i] != tl[i]) && !pause[i];
            dat[i]  = pk[i][hd[i] % 64][WD-1:0];
            last[i] = pk[i][hd[i] % 64][WD];
        end
    endtask

    // Reference: the packet owner keeps the channel; otherwise first valid from the pointer.
    task automatic step();
        int g;
        bit ld, acc;
        logic [N-1:0] er;
        beat_t b;
        drive();
        #1;
        ld = !m_ov || dataout_rdy;
        g = -1;
        if (m_owner >= 0) g = m_owner;
        else for (int k = 0; k < N; k++) if (g < 0 && val[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        er = (ld && g >= 0) ? N'(1) << g : '0;
        check("datain_rdy", int'(datain_rdy), int'(er));
        check("dataout_val", int'(dataout_val), int'(m_ov));
        acc = ld && g >= 0 && val[g];
        if (ld) m_ov = acc;
        if (acc) begin
            b.id = IDW'(g);
            b.l  = last[g];
            b.d  = dat[g];
            exp_q.push_back(b);
            if (last[g]) begin
                m_owner = -1;
                m_ptr = (g + 1) % N;
            end else m_owner = g;
            hd[g]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_ov = 0;
        m_owner = -1;
        m_ptr = 0;
        exp_q.delete();
        pause = '0;
        for (int i = 0; i < N; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("rst_dataout_val", int'(dataout_val), 0);
        check("rst_dataout", int'(dataout), 0);
        check("rst_dataout_id", int'(dataout_id), 0);
        check("rst_dataout_last", int'(dataout_last), 0);
        check("rst_datain_rdy", int'(datain_rdy), 0);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (rst_n && dataout_val && dataout_rdy) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_beat: got id %0d data %0d, expected no beat", dataout_id, dataout);
            end else begin
                e = exp_q.pop_front();
                check("dataout_id", int'(dataout_id), int'(e.id));
                check("dataout", int'(dataout), int'(e.d));
                check("dataout_last", int'(dataout_last), int'(e.l));
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) for (int j = 0; j < 64; j++) pk[i][j] = '0;
        dataout_rdy = 1'b1;
        do_reset();
        repeat (3) step();
        // fairness: every requester streams single-beat packets
        for (int r = 0; r < 4; r++) for (int i = 0; i < N; i++) push(i, i + 1, 1'b1);
        repeat (20) step();
        // packet lock: requester 2 must wait for requester 1's last beat
        push(1, 5, 1'b0); push(1, 6, 1'b0); push(1, 7, 1'b1); push(2, 9, 1'b1);
        repeat (6) step();
        // backpressure with a beat buffered
        push(0, 3, 1'b1); push(1, 4, 1'b1);
        step();
        dataout_rdy = 1'b0;
        repeat (3) step();
        dataout_rdy = 1'b1;
        repeat (4) step();
        // wrap: requester 3 then requester 0
        push(3, 8, 1'b1);
        step();
        push(0, 2, 1'b1);
        repeat (3) step();
        // owner drops valid mid-packet while requester 1 waits
        push(2, 10, 1'b0); push(2, 11, 1'b0); push(2, 12, 1'b1);
        step();
        push(1, 13, 1'b1);
        pause[2] = 1'b1;
        repeat (2) step();
        pause = '0;
        repeat (5) step();
        // random traffic with random backpressure and valid gaps
        for (int c = 0; c < 600; c++) begin
            dataout_rdy = $urandom_range(0, 3) != 0;
            pause = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++)
                if (tl[i] - hd[i] < 3 && $urandom_range(0, 1) == 1)
                    push(i, int'($urandom_range(0, 15)), $urandom_range(0, 2) == 0);
            step();
        end
        pause = '0;
        dataout_rdy = 1'b1;
        repeat (40) step();
        check("drain_random", exp_q.size(), 0);
        // reset while locked to requester 2
        do_reset();
        push(2, 4, 1'b0); push(2, 5, 1'b1);
        step();
        rst_n = 1'b0;
        #1;
        check("async_rst_val", int'(dataout_val), 0);
        do_reset();
        push(0, 1, 1'b1); push(2, 4, 1'b0); push(2, 5, 1'b1);
        repeat (6) step();
        check("drain_final", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rv_rr_arb.md
Name: rv_rr_arb

Overview:
- Round-robin arbiter sharing one valid-ready output channel among N valid-ready requesters.
- Packet-aware: a grant is held from a packet's first accepted beat through its last-flagged beat.
- Output is a full-throughput registered stage, so the shared consumer sees registered data, valid, source ID and last.
- Sits in front of the shared register-slice datapath and sequences which requester owns it.

Parameters:
wd, 4, data width per beat
N, 4, number of requesters (2..8)
IDW, 2, source-ID width; must satisfy 2^IDW >= N

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
datain_val  in  N  per-requester valid; bit i belongs to requester i
datain_rdy  out  N  per-requester ready; one-hot or zero
datain  in  N*wd  requester i data at bits [i*wd +: wd]
datain_last  in  N  per-requester end-of-packet flag, qualified by valid
dataout_val  out  1  output valid (registered)
dataout_rdy  in  1  downstream ready
dataout  out  wd  output data (registered)
dataout_id  out  IDW  index of the requester that supplied the beat (registered)
dataout_last  out  1  end-of-packet flag of the beat (registered)

Behaviour:
- Reset (async assert, sync deassert use): all of the following are 0: dataout_val, dataout, dataout_id, dataout_last, rr_ptr, owner; state=IDLE.
- Load enable: ld = !dataout_val || dataout_rdy.
- Arbitration:
  - IDLE: grant is the first i with datain_val[i]=1, scanning from rr_ptr upward modulo N. If no valid bit is set, there is no grant.
  - LOCKED: grant = owner, regardless of other valid bits.
- Ready: datain_rdy[i] = ld && grant_valid && (grant==i). Every other bit is 0, so at most one bit is high per cycle. Ready may depend on valid; valid must never depend on ready.
- Accept: accept = datain_val[g] && datain_rdy[g].
  - On accept, the output register loads dataout=datain slice g, dataout_id=g, dataout_last=datain_last[g], dataout_val=1.
  - If ld && !accept, dataout_val goes to 0.
  - If !ld, the output register holds all fields.
- State transitions (on accept only):
  - IDLE, last=0 -> LOCKED, owner=g.
  - IDLE, last=1 -> stays IDLE, rr_ptr=(g+1) mod N.
  - LOCKED, last=1 -> IDLE, rr_ptr=(owner+1) mod N.
  - LOCKED, last=0 -> stays LOCKED.
- Latency: 1 cycle from accept to dataout_val.
- Throughput: 1 beat/cycle while dataout_rdy=1, including back-to-back packets from different requesters with no bubble.
- Backpressure: with dataout_rdy=0 and dataout_val=1, all datain_rdy are 0 and the output holds stable; no beat is lost or duplicated.
- Single-beat packet (last=1 on the first beat): never enters LOCKED.
- Owner deasserts valid mid-packet: the arbiter stays LOCKED, and other requesters wait (no interleaving).
- rr_ptr wraps from N-1 to 0.
- Reset mid-packet: returns to IDLE and drops the buffered beat. Upstream must restart its packet.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, all datain_val=0 -> all outputs 0, datain_rdy=0000, dataout_val stays 0.
2. Fairness: dataout_rdy=1; requesters 0..3 each send continuous single-beat packets (datain = i+1, last=1) -> dataout_id sequence 0,1,2,3,0,… with dataout 1,2,3,4,1,…; one beat per cycle after 1-cycle latency.
3. Packet lock: requester 1 sends 3 beats (5,6,7; last on 7) while requester 2 is valid with 9 -> output 5,6,7 with id=1, then 9 with id=2. datain_rdy[2]=0 until beat 7 is accepted.
4. Backpressure: dataout_rdy=0 for 3 cycles with dataout=3 buffered -> dataout, dataout_id and dataout_val stay constant and datain_rdy=0000; on release, the next beat follows with no loss or duplicate.
5. Wrap and gap: requester 3 sends a single beat (8), then only requester 0 is valid -> id=3 then id=0. Separately, the owner drops valid mid-packet for 2 cycles with requester 1 valid -> requester 1 is not granted until the owner's last beat.
6. Reset mid-packet: assert rst_n=0 while LOCKED to requester 2 after beat 4 -> dataout_val=0 immediately. After release, requester 0's beat (value 1) is granted first (rr_ptr=0).
